// File: rtl/sensor_sample_arbiter.sv
// Round-robin arbiter sharing one isolation-tree scoring engine between NUM_CH
// sensor input buffers, with per-channel capture, overrun tracking and engine timeout.
module sensor_sample_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            chan_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] chan_data,
  output logic [NUM_CH-1:0]            chan_ack,
  output logic                         tree_valid,
  input  logic                         tree_ready,
  output logic [DATA_WIDTH-1:0]        tree_data,
  output logic [CW-1:0]                tree_chan,
  input  logic                         tree_done,
  output logic                         timeout_err,
  output logic [NUM_CH-1:0]            overrun,
  output logic [15:0]                  drop_count,
  input  logic                         stat_clr
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t                state, state_nx;
  logic [NUM_CH-1:0]     pending;
  logic [DATA_WIDTH-1:0] hold [NUM_CH];
  logic [CW-1:0]         rr, grant, pick;
  logic                  pick_ok;
  logic [TW-1:0]         wait_cnt;
  logic                  handshake;
  logic [NUM_CH-1:0]     issue_oh, ovr_ev;
  logic [16:0]           ovr_num, drop_sum;

  assign handshake = (state == ISSUE) && tree_ready;
  assign issue_oh  = handshake ? (NUM_CH'(1) << grant) : '0;

  // First pending channel at or after the round-robin pointer, wrapping.
  always_comb begin
    int unsigned sum;
    pick    = '0;
    pick_ok = 1'b0;
    sum     = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      sum = 32'(rr) + k;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      if (!pick_ok && pending[CW'(sum)]) begin
        pick    = CW'(sum);
        pick_ok = 1'b1;
      end
    end
  end

  // A capture on the channel being handed off this cycle is a fresh sample, not an overrun.
  always_comb begin
    ovr_ev  = chan_ready & pending & ~issue_oh;
    ovr_num = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) ovr_num = ovr_num + 17'(ovr_ev[i]);
    drop_sum = (stat_clr ? 17'd0 : {1'b0, drop_count}) + ovr_num;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending    <= '0;
      overrun    <= '0;
      drop_count <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) hold[i] <= '0;
    end else begin
      pending    <= (pending & ~issue_oh) | chan_ready;
      overrun    <= (stat_clr ? '0 : overrun) | ovr_ev;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      for (int unsigned i = 0; i < NUM_CH; i++)
        if (chan_ready[i]) hold[i] <= chan_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_ok) state_nx = ISSUE;
      ISSUE:   if (tree_ready) state_nx = WAIT;
      WAIT:    if (tree_done || wait_cnt == TW'(TIMEOUT - 1)) state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant       <= '0;
      rr          <= '0;
      wait_cnt    <= '0;
      tree_valid  <= 1'b0;
      tree_data   <= '0;
      tree_chan   <= '0;
      chan_ack    <= '0;
      timeout_err <= 1'b0;
    end else begin
      chan_ack    <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (pick_ok) begin
          grant      <= pick;
          tree_valid <= 1'b1;
          tree_data  <= hold[pick];
          tree_chan  <= pick;
        end
        ISSUE: if (tree_ready) begin
          tree_valid <= 1'b0;
          wait_cnt   <= '0;
        end
        WAIT: if (state_nx == ACK) begin
          chan_ack    <= NUM_CH'(1) << grant;
          timeout_err <= !tree_done;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
        ACK: rr <= (grant == CW'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_sample_arbiter.sv
// Scoreboard bench for sensor_sample_arbiter: a transaction-level model predicts grants,
// acks and overrun statistics; a negedge monitor pops and compares what the DUT presents.
module tb_sensor_sample_arbiter;
  localparam int NUM_CH = 4, DW = 8, TIMEOUT = 16, CW = 2;

  logic clk = 1'b0, reset = 1'b1;
  logic [NUM_CH-1:0]    chan_ready = '0;
  logic [NUM_CH*DW-1:0] chan_data  = '0;
  logic tree_ready = 1'b0, tree_done = 1'b0, stat_clr = 1'b0;
  logic [NUM_CH-1:0] chan_ack, overrun;
  logic              tree_valid, timeout_err;
  logic [DW-1:0]     tree_data;
  logic [CW-1:0]     tree_chan;
  logic [15:0]       drop_count;

  always #5 clk = ~clk;

  sensor_sample_arbiter #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .chan_ready(chan_ready), .chan_data(chan_data),
    .chan_ack(chan_ack), .tree_valid(tree_valid), .tree_ready(tree_ready),
    .tree_data(tree_data), .tree_chan(tree_chan), .tree_done(tree_done),
    .timeout_err(timeout_err), .overrun(overrun), .drop_count(drop_count),
    .stat_clr(stat_clr)
  );

  typedef struct { int unsigned ch; logic [DW-1:0] data; } grant_t;
  typedef struct { int unsigned ch; bit to; } ack_t;
  grant_t gq[$];
  ack_t   aq[$];
  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: samples wait in per-channel slots; the engine serves one at a time.
  logic [DW-1:0]     m_hold [NUM_CH];
  bit   [NUM_CH-1:0] m_pend = '0, m_ovr = '0;
  int unsigned       m_rr = 0, m_cur = 0, m_wcnt = 0, m_drop = 0;
  bit m_free = 1'b1, m_offer = 1'b0, m_score = 1'b0, m_ack = 1'b0, m_hs, m_found;

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_pend = '0; m_ovr = '0; m_drop = 0; m_rr = 0; m_cur = 0; m_wcnt = 0;
      m_free = 1'b1; m_offer = 1'b0; m_score = 1'b0; m_ack = 1'b0;
      for (int i = 0; i < NUM_CH; i++) m_hold[i] = '0;
      gq.delete(); aq.delete();
    end else begin
      m_hs = m_offer && tree_ready;
      if (stat_clr) begin m_ovr = '0; m_drop = 0; end
      for (int i = 0; i < NUM_CH; i++)
        if (chan_ready[i] && m_pend[i] && !(m_hs && m_cur == i)) begin
          m_ovr[i] = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      if (m_free) begin
        m_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++)
          if (!m_found && m_pend[(m_rr + k) % NUM_CH]) begin
            m_found = 1'b1;
            m_cur = (m_rr + k) % NUM_CH;
          end
        if (m_found) begin
          gq.push_back('{ch: m_cur, data: m_hold[m_cur]});
          m_free = 1'b0; m_offer = 1'b1;
        end
      end else if (m_offer) begin
        if (tree_ready) begin
          m_pend[m_cur] = 1'b0; m_offer = 1'b0; m_score = 1'b1; m_wcnt = 0;
        end
      end else if (m_score) begin
        if (tree_done || m_wcnt == TIMEOUT - 1) begin
          aq.push_back('{ch: m_cur, to: !tree_done});
          m_score = 1'b0; m_ack = 1'b1;
        end else m_wcnt++;
      end else if (m_ack) begin
        m_rr = (m_cur + 1) % NUM_CH; m_ack = 1'b0; m_free = 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++)
        if (chan_ready[i]) begin
          m_pend[i] = 1'b1; m_hold[i] = chan_data[i*DW +: DW];
        end
    end
  end

  // Monitor
  bit pv = 1'b0;
  grant_t g_cur = '{ch: 0, data: '0};
  ack_t   a_cur;
  initial forever begin
    @(negedge clk);
    if (reset) begin
      if (tree_valid) begin
        if (!pv) begin
          if (gq.size() == 0) chk("grant_unexpected", 32'(tree_valid), 32'd0);
          else g_cur = gq.pop_front();
        end
        chk("grant_chan", 32'(tree_chan), g_cur.ch);
        chk("grant_data", 32'(tree_data), 32'(g_cur.data));
      end
      if (chan_ack != '0) begin
        if (aq.size() == 0) chk("ack_unexpected", 32'(chan_ack), 32'd0);
        else begin
          a_cur = aq.pop_front();
          chk("ack_chan", 32'(chan_ack), 32'(1) << a_cur.ch);
          chk("ack_timeout", 32'(timeout_err), 32'(a_cur.to));
        end
      end else chk("timeout_without_ack", 32'(timeout_err), 32'd0);
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("drop_count", 32'(drop_count), m_drop);
    end
    pv = tree_valid && reset;
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int unsigned ch, input logic [DW-1:0] d);
    chan_ready = '0;
    chan_ready[ch] = 1'b1;
    chan_data[ch*DW +: DW] = d;
    @(negedge clk);
    chan_ready = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    run(2);
    chk("reset_outputs", {tree_valid, timeout_err, chan_ack, overrun, drop_count, tree_data, tree_chan}, 32'd0);
    reset = 1'b1;
    run(1);
  endtask

  initial begin
    #1 reset = 1'b0;
    run(2);
    chk("reset_outputs", {tree_valid, timeout_err, chan_ack, overrun, drop_count, tree_data, tree_chan}, 32'd0);
    reset = 1'b1;
    run(1);

    // Single sample, two-cycle latency
    tree_ready = 1'b1;
    pulse(2, 8'hA5);
    chk("lat1_valid", 32'(tree_valid), 32'd0);
    run(1);
    chk("lat2_valid", 32'(tree_valid), 32'd1);
    chk("lat2_data", 32'(tree_data), 32'hA5);
    chk("lat2_chan", 32'(tree_chan), 32'd2);
    run(2); tree_done = 1'b1; run(1); tree_done = 1'b0;
    run(5);

    // Fairness from rr=0: all channels at once, then ch1 alone
    do_reset();
    tree_done = 1'b1;
    chan_ready = '1; chan_data = 32'h44332211;
    run(1);
    chan_ready = '0;
    run(30);
    pulse(1, 8'h5C);
    run(10);

    // Backpressure
    tree_ready = 1'b0;
    pulse(3, 8'h3C);
    run(10);
    chk("bp_valid_held", 32'(tree_valid), 32'd1);
    tree_ready = 1'b1;
    run(8);

    // Overrun while engine busy on ch0, then statistics clear
    stat_clr = 1'b1; run(1); stat_clr = 1'b0;
    tree_done = 1'b0;
    pulse(0, 8'h50);
    run(3);
    pulse(1, 8'h01);
    pulse(1, 8'h02);
    chk("ovr_flags", 32'(overrun), 32'h2);
    chk("ovr_drops", 32'(drop_count), 32'd1);
    tree_done = 1'b1;
    run(20);
    stat_clr = 1'b1; run(1); stat_clr = 1'b0;
    chk("clr_flags", 32'(overrun), 32'd0);
    chk("clr_drops", 32'(drop_count), 32'd0);

    // Engine timeout
    tree_done = 1'b0;
    pulse(0, 8'h77);
    run(25);

    // Reset while waiting on the engine, then normal service
    pulse(2, 8'h99);
    run(4);
    do_reset();
    tree_done = 1'b1;
    pulse(1, 8'h42);
    run(10);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_CH; i++) chan_ready[i] = ($urandom_range(0, 5) == 0);
      chan_data  = $urandom;
      tree_ready = 1'($urandom_range(0, 1));
      tree_done  = ($urandom_range(0, 7) == 0);
      stat_clr   = ($urandom_range(0, 49) == 0);
      run(1);
    end
    chan_ready = '0; stat_clr = 1'b0; tree_ready = 1'b1; tree_done = 1'b1;
    run(60);
    chk("grants_drained", gq.size(), 32'd0);
    chk("acks_drained", aq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
